// File: rtl/brick_field_if.sv
// Brick-erase bus: the ball block reports which brick it hit.
interface brick_field_if;
  logic       erase_enable;
  logic [5:0] e_pos;

  modport master (output erase_enable, e_pos);
  modport slave  (input  erase_enable, e_pos);
endinterface

// File: rtl/brick_field.sv
// Brick field: per-brick live/flash/dead state, per-pixel brick colour,
// score and clear status for a 2x5 brick wall.
module brick_field #(
  parameter logic [9:0] BLOCK_SPACING_X = 10'd40,
  parameter logic [9:0] BLOCK_WIDTH     = 10'd80,
  parameter logic [9:0] BLOCK_HEIGHT    = 10'd30,
  parameter logic [9:0] FIRST_ROW_Y     = 10'd40,
  parameter logic [9:0] SECOND_ROW_Y    = 10'd90,
  parameter logic [2:0] FLASH_FRAMES    = 3'd6,
  parameter logic [9:0] SCORE_PER_BRICK = 10'd10,
  parameter logic [7:0] ROW0_COLOR      = 8'hE0,
  parameter logic [7:0] ROW1_COLOR      = 8'h1C,
  parameter logic [7:0] FLASH_COLOR     = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  brick_field_if.slave      erase,
  input  logic              frame_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  output logic              block_on,
  output logic [7:0]        rgb,
  output logic [9:0]        score,
  output logic [3:0]        bricks_left,
  output logic              all_clear
);

  localparam int unsigned NUM_BRICKS = 10;
  localparam logic [10:0] SCORE_MAX  = 11'd999;

  typedef enum logic [1:0] {ALIVE, FLASH, DEAD} brick_state_t;

  brick_state_t state_q [NUM_BRICKS];
  brick_state_t state_d [NUM_BRICKS];
  logic [2:0]   cnt_q   [NUM_BRICKS];
  logic [2:0]   cnt_d   [NUM_BRICKS];

  logic [NUM_BRICKS-1:0] in_brick;
  logic                  accept;
  logic                  hit_on;
  logic [7:0]            hit_rgb;
  logic [3:0]            alive_cnt;
  logic                  all_dead;
  logic [10:0]           score_sum;

  // Brick rectangles; corners fold to constants per brick.
  for (genvar g = 0; g < NUM_BRICKS; g++) begin : g_geom
    localparam logic [9:0] X0 =
      10'(BLOCK_SPACING_X + (BLOCK_WIDTH + BLOCK_SPACING_X) * (g % 5));
    localparam logic [9:0] Y0 = (g < 5) ? FIRST_ROW_Y : SECOND_ROW_Y;
    assign in_brick[g] = (pixel_x >= X0) && (pixel_x < X0 + BLOCK_WIDTH) &&
                         (pixel_y >= Y0) && (pixel_y < Y0 + BLOCK_HEIGHT);
  end

  // Brick state and flash counter registers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      if (reset) begin
        state_q[i] <= ALIVE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state per brick; a load on an ALIVE brick cannot coincide with a
  // decrement because only FLASH bricks count frames.
  always_comb begin
    accept = 1'b0;
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ALIVE: begin
          if (erase.erase_enable && erase.e_pos == 6'(i)) begin
            state_d[i] = FLASH;
            cnt_d[i]   = FLASH_FRAMES;
            accept     = 1'b1;
          end
        end
        FLASH: begin
          if (frame_tick) begin
            cnt_d[i] = cnt_q[i] - 3'd1;
            if (cnt_q[i] == 3'd1) state_d[i] = DEAD;
          end
        end
        DEAD:    ;
        default: state_d[i] = ALIVE;
      endcase
    end
  end

  // Pixel colour and status derived from the current brick states.
  always_comb begin
    hit_on    = 1'b0;
    hit_rgb   = '0;
    alive_cnt = '0;
    all_dead  = 1'b1;
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      if (state_q[i] == ALIVE) alive_cnt = alive_cnt + 4'd1;
      if (state_q[i] != DEAD)  all_dead  = 1'b0;
      if (in_brick[i]) begin
        if (state_q[i] == ALIVE) begin
          hit_on  = 1'b1;
          hit_rgb = (i < 5) ? ROW0_COLOR : ROW1_COLOR;
        end else if (state_q[i] == FLASH && !cnt_q[i][0]) begin
          hit_on  = 1'b1;
          hit_rgb = FLASH_COLOR;
        end
      end
    end
    score_sum = {1'b0, score} + {1'b0, SCORE_PER_BRICK};
  end

  // Registered pixel output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_on <= 1'b0;
      rgb      <= '0;
    end else begin
      block_on <= video_on && hit_on;
      rgb      <= (video_on && hit_on) ? hit_rgb : '0;
    end
  end

  // Score accumulation with saturation, and registered status.
  always_ff @(posedge clk) begin
    if (reset) begin
      score       <= '0;
      bricks_left <= 4'd10;
      all_clear   <= 1'b0;
    end else begin
      if (accept)
        score <= (score_sum > SCORE_MAX) ? SCORE_MAX[9:0] : score_sum[9:0];
      bricks_left <= alive_cnt;
      all_clear   <= all_dead;
    end
  end

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: pixel table, hand sequences for
// flash timing / ignores / saturation, then random traffic against a model.
module tb_brick_field;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on;
  logic       block_on, s_block_on, all_clear, s_all_clear;
  logic [7:0] rgb, s_rgb;
  logic [9:0] score, s_score;
  logic [3:0] bricks_left, s_bricks_left;

  brick_field_if bus ();
  brick_field_if sbus ();

  brick_field u_dut (
    .clk(clk), .reset(reset), .erase(bus), .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .block_on(block_on), .rgb(rgb), .score(score),
    .bricks_left(bricks_left), .all_clear(all_clear)
  );

  brick_field #(.SCORE_PER_BRICK(10'd200)) u_sat (
    .clk(clk), .reset(reset), .erase(sbus), .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .block_on(s_block_on), .rgb(s_rgb), .score(s_score),
    .bricks_left(s_bricks_left), .all_clear(s_all_clear)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int x; int y; int von; int on; int col;
  } pix_vec_t;

  pix_vec_t vec [12];

  // reference model: brick status 0 alive / 1 flashing / 2 dead
  int m_state [10];
  int m_cnt   [10];
  int m_score;
  int e_on, e_rgb, e_left, e_clear;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic erase_cycle(input int pos);
    bus.erase_enable = 1'b1;
    bus.e_pos = 6'(pos);
    tick();
    bus.erase_enable = 1'b0;
  endtask

  // Which brick (if any) covers the pixel, from plain wall arithmetic.
  function automatic int brick_at(input int x, input int y);
    int row, rx, col;
    row = -1;
    if (y >= 40 && y < 70) row = 0;
    else if (y >= 90 && y < 120) row = 1;
    if (row < 0 || x < 40) return -1;
    rx = x - 40;
    col = rx / 120;
    if (col < 5 && (rx % 120) < 80) return row * 5 + col;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_state[i] = 0;
      m_cnt[i] = 0;
    end
    m_score = 0;
  endtask

  // Expected outputs after the coming clock edge, given the current inputs.
  task automatic model_step();
    int idx, nalive, ndead, p;
    idx = brick_at(int'(pixel_x), int'(pixel_y));
    e_on = 0; e_rgb = 0; nalive = 0; ndead = 0;
    if (video_on && idx >= 0) begin
      if (m_state[idx] == 0) begin
        e_on = 1;
        e_rgb = (idx < 5) ? 8'hE0 : 8'h1C;
      end else if (m_state[idx] == 1 && (m_cnt[idx] % 2) == 0) begin
        e_on = 1;
        e_rgb = 8'hFF;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (m_state[i] == 0) nalive++;
      if (m_state[i] == 2) ndead++;
    end
    e_left = nalive;
    e_clear = (ndead == 10);
    if (reset) begin
      model_reset();
      e_on = 0; e_rgb = 0; e_left = 10; e_clear = 0;
      return;
    end
    if (frame_tick)
      for (int i = 0; i < 10; i++)
        if (m_state[i] == 1) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) m_state[i] = 2;
        end
    p = int'(bus.e_pos);
    if (bus.erase_enable && p < 10 && m_state[p] == 0) begin
      m_state[p] = 1;
      m_cnt[p] = 6;
      m_score = (m_score + 10 > 999) ? 999 : m_score + 10;
    end
  endtask

  task automatic cyc();
    model_step();
    tick();
    check("rnd_block_on", int'(block_on), e_on);
    check("rnd_rgb", int'(rgb), e_rgb);
    check("rnd_score", int'(score), m_score);
    check("rnd_bricks_left", int'(bricks_left), e_left);
    check("rnd_all_clear", int'(all_clear), e_clear);
  endtask

  // Six frame pulses on the flashing brick under the current pixel;
  // counter 6..1 shows on even counts, then the brick is gone.
  task automatic flash_seq(input string tag);
    int exp;
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      exp = (k < 6 && ((6 - k) % 2) == 0) ? 1 : 0;
      check({tag, "_on"}, int'(block_on), exp);
      check({tag, "_rgb"}, int'(rgb), exp ? 8'hFF : 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec[0]  = '{50, 45, 1, 1, 8'hE0};
    vec[1]  = '{125, 45, 1, 0, 0};
    vec[2]  = '{40, 40, 1, 1, 8'hE0};
    vec[3]  = '{119, 69, 1, 1, 8'hE0};
    vec[4]  = '{120, 40, 1, 0, 0};
    vec[5]  = '{39, 40, 1, 0, 0};
    vec[6]  = '{40, 70, 1, 0, 0};
    vec[7]  = '{50, 45, 0, 0, 0};
    vec[8]  = '{330, 100, 1, 1, 8'h1C};
    vec[9]  = '{560, 119, 1, 1, 8'h1C};
    vec[10] = '{600, 95, 1, 0, 0};
    vec[11] = '{50, 89, 1, 0, 0};

    reset = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0;
    bus.erase_enable = 1'b0; bus.e_pos = '0;
    sbus.erase_enable = 1'b0; sbus.e_pos = '0;
    tick();
    do_reset();

    check("rst_score", int'(score), 0);
    check("rst_bricks_left", int'(bricks_left), 10);
    check("rst_all_clear", int'(all_clear), 0);
    check("rst_block_on", int'(block_on), 0);
    check("rst_rgb", int'(rgb), 0);

    // geometry table
    for (int i = 0; i < 12; i++) begin
      pixel_x = 10'(vec[i].x);
      pixel_y = 10'(vec[i].y);
      video_on = (vec[i].von != 0);
      tick();
      check($sformatf("pix%0d_on", i), int'(block_on), vec[i].on);
      check($sformatf("pix%0d_rgb", i), int'(rgb), vec[i].col);
    end

    // saturating score on the 200-per-brick instance
    for (int i = 0; i < 6; i++) begin
      sbus.erase_enable = 1'b1;
      sbus.e_pos = 6'(i);
      tick();
      sbus.erase_enable = 1'b0;
      check($sformatf("sat_score%0d", i), int'(s_score), (i < 4) ? 200 * (i + 1) : 999);
    end

    // erase brick 7 and watch it flash
    pixel_x = 10'd330; pixel_y = 10'd100; video_on = 1'b1;
    erase_cycle(7);
    check("e7_score", int'(score), 10);
    tick();
    check("e7_bricks_left", int'(bricks_left), 9);
    check("e7_first_on", int'(block_on), 1);
    check("e7_first_rgb", int'(rgb), 8'hFF);
    erase_cycle(7);
    tick();
    check("e7_flash_reerase_score", int'(score), 10);
    flash_seq("e7");
    repeat (3) tick();
    check("e7_dead_on", int'(block_on), 0);
    erase_cycle(7);
    tick();
    check("e7_dead_reerase_score", int'(score), 10);
    check("e7_dead_reerase_left", int'(bricks_left), 9);

    // out-of-range indices
    erase_cycle(10);
    erase_cycle(63);
    tick();
    check("oor_score", int'(score), 10);
    check("oor_bricks_left", int'(bricks_left), 9);
    check("oor_all_clear", int'(all_clear), 0);

    // erase brick 3 together with a frame tick: counter starts at 6
    pixel_x = 10'd420; pixel_y = 10'd50;
    frame_tick = 1'b1;
    erase_cycle(3);
    frame_tick = 1'b0;
    tick();
    check("e3_load_on", int'(block_on), 1);
    check("e3_score", int'(score), 20);
    flash_seq("e3");
    check("e3_bricks_left", int'(bricks_left), 8);

    // clear the rest of the wall
    foreach (vec[i]) ; // keeps vec referenced by a loop form only once
    erase_cycle(0); erase_cycle(1); erase_cycle(2); erase_cycle(4);
    erase_cycle(5); erase_cycle(6); erase_cycle(8); erase_cycle(9);
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      check($sformatf("clr_all_clear_f%0d", k), int'(all_clear), (k == 6) ? 1 : 0);
    end
    check("clr_score", int'(score), 100);
    check("clr_bricks_left", int'(bricks_left), 0);

    // reset returns everything
    pixel_x = 10'd50; pixel_y = 10'd45;
    do_reset();
    check("rst2_score", int'(score), 0);
    check("rst2_bricks_left", int'(bricks_left), 10);
    check("rst2_all_clear", int'(all_clear), 0);
    check("rst2_sat_score", int'(s_score), 0);
    tick();
    check("rst2_block_on", int'(block_on), 1);
    check("rst2_rgb", int'(rgb), 8'hE0);

    // random traffic against the model
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      bus.erase_enable = ($urandom_range(0, 5) == 0);
      bus.e_pos = 6'($urandom_range(0, 11));
      pixel_x = 10'($urandom_range(0, 639));
      pixel_y = 10'($urandom_range(30, 130));
      video_on = ($urandom_range(0, 7) != 0);
      cyc();
    end
    reset = 1'b0;
    bus.erase_enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/brick_field.md
Name: brick_field

Overview:
- Receiving end of the ball's brick-erase interface (`erase_enable`, `e_pos`).
- Holds the live/dying/dead state of the 10 bricks and runs a frame-counted flash animation on each hit brick.
- Supplies per-pixel brick colour to the VGA pixel mux, plus score, remaining-brick count and all-clear status.
- Sits between the ball block, the VGA sync generator and the top-level colour mux.

Parameters:
- BLOCK_SPACING_X, 10'd40, left margin and horizontal gap between bricks
- BLOCK_WIDTH, 10'd80, brick width in pixels
- BLOCK_HEIGHT, 10'd30, brick height in pixels
- FIRST_ROW_Y, 10'd40, top y of bricks 0-4
- SECOND_ROW_Y, 10'd90, top y of bricks 5-9
- FLASH_FRAMES, 3'd6, frames a hit brick flashes before vanishing (1-7)
- SCORE_PER_BRICK, 10'd10, score increment per brick
- ROW0_COLOR, 8'hE0, RGB332 colour of row 0
- ROW1_COLOR, 8'h1C, RGB332 colour of row 1
- FLASH_COLOR, 8'hFF, RGB332 colour shown in flash-on frames

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high
- erase_enable  in  1  single-cycle strobe: brick e_pos was hit
- e_pos  in  6  brick index, valid when erase_enable=1
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- video_on  in  1  active display region
- block_on  out  1  registered: current pixel lies on a visible brick
- rgb  out  8  registered RGB332 brick colour, 0 when not block_on
- score  out  10  accumulated score, saturating
- bricks_left  out  4  number of bricks in ALIVE state
- all_clear  out  1  all 10 bricks in DEAD state

Behaviour:
- Brick geometry:
  - Brick i (0-4): x0 = BLOCK_SPACING_X + (BLOCK_WIDTH + BLOCK_SPACING_X)*i, y0 = FIRST_ROW_Y.
  - Brick i (5-9): same x0 formula using column i-5, y0 = SECOND_ROW_Y.
  - A pixel is inside when x0 <= pixel_x < x0+BLOCK_WIDTH and y0 <= pixel_y < y0+BLOCK_HEIGHT.
  - x0 values are elaboration-time constants; no runtime multiplier.
- Per-brick FSM, 10 instances, each with a 3-bit flash counter:
  - ALIVE: on erase_enable with e_pos==i, go to FLASH, load counter=FLASH_FRAMES, add score.
  - FLASH: on each frame_tick, decrement the counter; when counter==1 and frame_tick, go to DEAD.
  - DEAD: stays DEAD until reset.
- Erase requests:
  - Erase of a FLASH or DEAD brick is ignored: no score, no state change.
  - e_pos >= 10 is ignored.
- Simultaneous events:
  - erase_enable and frame_tick in the same cycle on the same ALIVE brick: load wins, no decrement that cycle.
  - frame_tick still decrements all other flashing bricks in that cycle.
- Score:
  - score <= score + SCORE_PER_BRICK, computed in 11 bits and saturated at 10'd999.
  - Updates the cycle after erase_enable.
- Status outputs:
  - bricks_left is a registered count of ALIVE bricks and updates the cycle after the state change.
  - all_clear is registered: 1 iff all 10 bricks are DEAD. It is not asserted while any brick is still flashing.
- Pixel path: one register stage, 1-cycle latency from pixel_x/pixel_y/video_on to block_on/rgb.
  - ALIVE brick hit: rgb = ROW0_COLOR or ROW1_COLOR by row.
  - FLASH brick hit, counter[0]==0: rgb = FLASH_COLOR.
  - FLASH brick hit, counter[0]==1: brick invisible (block_on=0).
  - DEAD brick: invisible.
  - video_on=0 forces block_on=0, rgb=0.
  - Bricks do not overlap, so at most one match per pixel; no priority logic is needed.
- Reset values: all bricks ALIVE, counters 0, score 0, bricks_left 10, all_clear 0, block_on 0, rgb 0.
  - Reset takes precedence over any erase or frame_tick in the same cycle.
  - Reset mid-flash returns the brick to ALIVE.

Test Plan:
- Reset, then pixel (50,45) with video_on=1 -> next cycle block_on=1, rgb=8'hE0; pixel (125,45) -> block_on=0 (gap between bricks); pixel (40,40) on, (119,69) on, (120,40) off (edge checks).
- erase_enable, e_pos=7 -> score=10, bricks_left=9; at pixel (330,100), frames alternate rgb=8'hFF and block_on=0; after 6 frame_ticks block_on stays 0.
- erase of brick 7 repeated during FLASH and again after DEAD -> score stays 10, bricks_left stays 9.
- erase_enable with e_pos=10 and with e_pos=63 -> no change to any output.
- erase brick 3 and frame_tick in the same cycle -> counter=6; brick 3 turns DEAD exactly on the 6th subsequent tick.
- Erase all 10 bricks -> all_clear=0 until the last flash ends, then all_clear=1 and score=100. Preload score near saturation (SCORE_PER_BRICK=10'd200) -> score saturates at 999. Assert reset -> all outputs return to reset values.
